// File: rtl/conv_stream_feeder.sv
// conv_stream_feeder: packs a serial weight/pixel element stream into the convolution
// core's AXI-Stream input words. A frame is KERNEL_SIZE^2 weights, packed EPW per word
// and MSB-first, then an idle gap, then KERNEL_SIZE pixel rows at one row per word.
// Optional feature macro: FEEDER_TLAST_EN adds m_axis_tlast, which marks the last weight
// word and the last data word of each frame.
module conv_stream_feeder #(
    parameter int unsigned KERNEL_SIZE  = 3,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned WEIGHT_WIDTH = 8,
    parameter int unsigned BUS_WIDTH    = 32,
    parameter int unsigned GAP_CYCLES   = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic [DATA_WIDTH-1:0] s_elem_tdata,
    input  logic                  s_elem_tvalid,
    output logic                  s_elem_tready,
    output logic [BUS_WIDTH-1:0]  m_axis_tdata,
    output logic                  m_axis_tvalid,
`ifdef FEEDER_TLAST_EN
    output logic                  m_axis_tlast,
`endif
    input  logic                  m_axis_tready
);

    localparam int unsigned EPW = BUS_WIDTH / DATA_WIDTH;
    localparam int unsigned KK  = KERNEL_SIZE * KERNEL_SIZE;
    localparam int unsigned EW  = (EPW > 1) ? $clog2(EPW) : 1;
    localparam int unsigned WW  = $clog2(KK + 1);
    localparam int unsigned RW  = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam int unsigned GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [EW-1:0] ELEM_LAST_W = EW'(EPW - 1);
    localparam logic [EW-1:0] ELEM_LAST_D = EW'(KERNEL_SIZE - 1);
    localparam logic [WW-1:0] WGT_LAST    = WW'(KK - 1);
    localparam logic [WW-1:0] WGT_ALL     = WW'(KK);
    localparam logic [RW-1:0] ROW_LAST    = RW'(KERNEL_SIZE - 1);
    localparam logic [GW-1:0] GAP_LAST    = GW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    if (WEIGHT_WIDTH != DATA_WIDTH) begin : g_err_weight_width
        $error("conv_stream_feeder: WEIGHT_WIDTH must equal DATA_WIDTH");
    end
    if ((BUS_WIDTH < KERNEL_SIZE * DATA_WIDTH) || (BUS_WIDTH % DATA_WIDTH != 0)) begin : g_err_bus
        $error("conv_stream_feeder: BUS_WIDTH must hold a row and be a multiple of DATA_WIDTH");
    end

    typedef enum logic [2:0] {
        StIdle,
        StWPack,
        StWSend,
        StGap,
        StDPack,
        StDSend,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [BUS_WIDTH-1:0] pack_q, pack_d;
    logic [EW-1:0]        elem_q, elem_d;  // lane of the next element within the word
    logic [WW-1:0]        wgt_q, wgt_d;    // weights taken so far in this frame
    logic [RW-1:0]        row_q, row_d;    // data row currently being packed/sent
    logic [GW-1:0]        gap_q, gap_d;
    logic [BUS_WIDTH-1:0] lane_word;

    // Pack register with the incoming element dropped into lane elem_q.
    always_comb begin
        lane_word = pack_q;
        for (int i = 0; i < int'(EPW); i++) begin
            if (elem_q == EW'(i)) begin
                lane_word[BUS_WIDTH-1-i*DATA_WIDTH -: DATA_WIDTH] = s_elem_tdata;
            end
        end
    end

    // Next-state, counter and handshake logic.
    always_comb begin
        state_d       = state_q;
        pack_d        = pack_q;
        elem_d        = elem_q;
        wgt_d         = wgt_q;
        row_d         = row_q;
        gap_d         = gap_q;
        busy          = (state_q != StIdle);
        done          = 1'b0;
        s_elem_tready = 1'b0;
        m_axis_tvalid = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StWPack;
                end
            end
            StWPack: begin
                s_elem_tready = 1'b1;
                if (s_elem_tvalid) begin
                    pack_d = lane_word;
                    wgt_d  = wgt_q + 1'b1;
                    if ((elem_q == ELEM_LAST_W) || (wgt_q == WGT_LAST)) begin
                        elem_d  = '0;
                        state_d = StWSend;
                    end else begin
                        elem_d = elem_q + 1'b1;
                    end
                end
            end
            StWSend: begin
                m_axis_tvalid = 1'b1;
                if (m_axis_tready) begin
                    pack_d = '0;
                    if (wgt_q == WGT_ALL) begin
                        wgt_d   = '0;
                        state_d = (GAP_CYCLES == 0) ? StDPack : StGap;
                    end else begin
                        state_d = StWPack;
                    end
                end
            end
            StGap: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = StDPack;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            StDPack: begin
                s_elem_tready = 1'b1;
                if (s_elem_tvalid) begin
                    pack_d = lane_word;
                    if (elem_q == ELEM_LAST_D) begin
                        elem_d  = '0;
                        state_d = StDSend;
                    end else begin
                        elem_d = elem_q + 1'b1;
                    end
                end
            end
            StDSend: begin
                m_axis_tvalid = 1'b1;
                if (m_axis_tready) begin
                    pack_d = '0;
                    if (row_q == ROW_LAST) begin
                        row_d   = '0;
                        state_d = StDone;
                    end else begin
                        row_d   = row_q + 1'b1;
                        state_d = StDPack;
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // The pack register is the output word; it only changes in PACK states, so tdata is
    // stable for as long as a SEND state holds tvalid.
    assign m_axis_tdata = pack_q;

`ifdef FEEDER_TLAST_EN
    assign m_axis_tlast = ((state_q == StWSend) && (wgt_q == WGT_ALL)) ||
                          ((state_q == StDSend) && (row_q == ROW_LAST));
`endif

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
            pack_q  <= '0;
            elem_q  <= '0;
            wgt_q   <= '0;
            row_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            pack_q  <= pack_d;
            elem_q  <= elem_d;
            wgt_q   <= wgt_d;
            row_q   <= row_d;
            gap_q   <= gap_d;
        end
    end

endmodule

// File: tb/tb_conv_stream_feeder.sv
// Bench for conv_stream_feeder: directed frames checked cycle by cycle against a
// frame-level model, plus literal word/timing expectations. Honours FEEDER_TLAST_EN.
module tb_conv_stream_feeder;

    localparam int K    = 3;
    localparam int DW   = 8;
    localparam int BW   = 32;
    localparam int GAP  = 4;
    localparam int EPW  = BW / DW;
    localparam int KK   = K * K;
    localparam int NWW  = (KK + EPW - 1) / EPW;
    localparam int NWRD = NWW + K;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic          busy, done;
    logic [DW-1:0] s_elem_tdata = '0;
    logic          s_elem_tvalid = 1'b0;
    logic          s_elem_tready;
    logic [BW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;

    logic          g_start = 1'b0;
    logic          g_busy, g_done;
    logic [DW-1:0] g_s_tdata = '0;
    logic          g_s_tvalid = 1'b0;
    logic          g_s_tready;
    logic [BW-1:0] g_m_tdata;
    logic          g_m_tvalid;
    logic          g_m_tready = 1'b1;

`ifdef FEEDER_TLAST_EN
    logic          m_axis_tlast;
    logic          g_tlast;
`endif

    int            vectors = 0;
    int            miscompares = 0;
    bit            stall_mode = 1'b0;
    int            done_cnt = 0;
    int            stall_cycles = 0;
    int            g_done_cnt = 0;
    logic [BW-1:0] obs_q[$];
    logic [BW-1:0] g_obs_q[$];

    logic [DW-1:0] px[9]   = '{8'd10, 8'd13, 8'd16, 8'd11, 8'd14, 8'd17, 8'd12, 8'd15, 8'd18};
    logic [BW-1:0] gold[6] = '{32'h01020304, 32'h05060708, 32'h09000000,
                               32'h0a0d1000, 32'h0b0e1100, 32'h0c0f1200};

    always #5 clk = ~clk;

    conv_stream_feeder #(
        .KERNEL_SIZE (K),
        .DATA_WIDTH  (DW),
        .WEIGHT_WIDTH(DW),
        .BUS_WIDTH   (BW),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .s_elem_tdata (s_elem_tdata),
        .s_elem_tvalid(s_elem_tvalid),
        .s_elem_tready(s_elem_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
`ifdef FEEDER_TLAST_EN
        .m_axis_tlast (m_axis_tlast),
`endif
        .m_axis_tready(m_axis_tready)
    );

    conv_stream_feeder #(
        .KERNEL_SIZE (K),
        .DATA_WIDTH  (DW),
        .WEIGHT_WIDTH(DW),
        .BUS_WIDTH   (BW),
        .GAP_CYCLES  (0)
    ) dut_g0 (
        .clk          (clk),
        .rstn         (rstn),
        .start        (g_start),
        .busy         (g_busy),
        .done         (g_done),
        .s_elem_tdata (g_s_tdata),
        .s_elem_tvalid(g_s_tvalid),
        .s_elem_tready(g_s_tready),
        .m_axis_tdata (g_m_tdata),
        .m_axis_tvalid(g_m_tvalid),
`ifdef FEEDER_TLAST_EN
        .m_axis_tlast (g_tlast),
`endif
        .m_axis_tready(g_m_tready)
    );

    task automatic chk32(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got timeout, expected event (t=%0t)", name, $time);
    endtask

    // Frame-level model: groups accepted elements into words, tracks the expected word
    // queue, the post-weight gap, busy/done, and checks every DUT output each cycle.
    task automatic compare_loop();
        logic [BW-1:0] exp_q[$];
        int            kind_q[$];  // 0 plain, 1 last weight word, 2 last data word
        logic [BW-1:0] cur = '0;
        int            grp_n = 0;
        int            e_idx = 0;
        int            gap_left = 0;
        bit            m_busy = 1'b0;
        bit            m_done = 1'b0;
        bit            m_done_n;
        bit            post_rst = 1'b0;
        bit            exp_ready;
        bit            full;
        forever begin
            @(negedge clk);
            exp_ready = m_busy && !m_done && (exp_q.size() == 0) && (gap_left == 0);
            chk1("busy", busy, m_busy);
            chk1("done", done, m_done);
            chk1("s_elem_tready", s_elem_tready, exp_ready);
            chk1("m_axis_tvalid", m_axis_tvalid, exp_q.size() != 0);
            if (exp_q.size() != 0) chk32("m_axis_tdata", m_axis_tdata, exp_q[0]);
`ifdef FEEDER_TLAST_EN
            chk1("m_axis_tlast", m_axis_tlast, (exp_q.size() != 0) && (kind_q[0] != 0));
`endif
            if (post_rst) chk32("m_axis_tdata after reset", m_axis_tdata, '0);
            if (done) done_cnt++;
            if (m_axis_tvalid && !m_axis_tready) stall_cycles++;

            if (!rstn) begin
                exp_q.delete();
                kind_q.delete();
                cur = '0; grp_n = 0; e_idx = 0; gap_left = 0;
                m_busy = 1'b0; m_done = 1'b0; post_rst = 1'b1;
                continue;
            end
            post_rst = 1'b0;
            m_done_n = 1'b0;

            if (m_axis_tvalid && m_axis_tready && (exp_q.size() != 0)) begin
                obs_q.push_back(m_axis_tdata);
                if (kind_q[0] == 1) gap_left = GAP;
                if (kind_q[0] == 2) m_done_n = 1'b1;
                void'(exp_q.pop_front());
                void'(kind_q.pop_front());
            end else if (gap_left > 0) begin
                gap_left--;
            end

            if (s_elem_tvalid && exp_ready) begin
                cur = cur | (BW'(s_elem_tdata) << (BW - DW * (grp_n + 1)));
                grp_n++;
                full = (e_idx < KK) ? ((grp_n == EPW) || (e_idx == KK - 1)) : (grp_n == K);
                if (full) begin
                    exp_q.push_back(cur);
                    kind_q.push_back((e_idx == KK - 1) ? 1 : ((e_idx == 2 * KK - 1) ? 2 : 0));
                    cur = '0;
                    grp_n = 0;
                end
                e_idx = (e_idx == 2 * KK - 1) ? 0 : e_idx + 1;
            end

            if (m_done) m_busy = 1'b0;
            else if (start && !m_busy) m_busy = 1'b1;
            m_done = m_done_n;
        end
    endtask

    // Holds m_axis_tready low for 5 cycles at the start of every word when stalling.
    task automatic ready_driver();
        int held = 0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_mode && m_axis_tvalid && held < 5) begin
                m_axis_tready = 1'b0;
                held++;
            end else begin
                m_axis_tready = 1'b1;
                if (!m_axis_tvalid) held = 0;
            end
        end
    endtask

    // Zero-gap instance: the data phase must accept an element right after the last
    // weight word handshake.
    task automatic g0_monitor();
        bit next_chk = 1'b0;
        forever begin
            @(negedge clk);
            if (next_chk) begin
                chk1("g0 no gap: s_elem_tready after last weight word", g_s_tready, 1'b1);
                next_chk = 1'b0;
            end
            if (g_done) g_done_cnt++;
            if (g_m_tvalid && g_m_tready) begin
                g_obs_q.push_back(g_m_tdata);
`ifdef FEEDER_TLAST_EN
                chk1("g0 m_axis_tlast", g_tlast,
                     (g_obs_q.size() == NWW) || (g_obs_q.size() == NWRD));
`endif
                if (g_obs_q.size() == NWW) next_chk = 1'b1;
            end
        end
    endtask

    task automatic push_elem(input logic [DW-1:0] v, input bit toggle);
        int n = 0;
        s_elem_tdata  = v;
        s_elem_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_elem_tready) break;
            n++;
            if (n > 300) begin
                timeout_fail("push_elem handshake");
                break;
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        if (toggle) begin
            s_elem_tvalid = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_g0(input logic [DW-1:0] v);
        int n = 0;
        g_s_tdata  = v;
        g_s_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (g_s_tready) break;
            n++;
            if (n > 300) begin
                timeout_fail("g0 push handshake");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        forever begin
            @(negedge clk);
            if (!busy && !g_busy) break;
            n++;
            if (n > 500) begin
                timeout_fail("wait for busy low");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Start together with a valid element (must not be taken), then a full frame.
    task automatic run_frame(input bit toggle, input bit start_mid);
        start         = 1'b1;
        s_elem_tdata  = 8'd1;
        s_elem_tvalid = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < KK; i++) begin
            push_elem(DW'(i + 1), toggle);
            if (start_mid && i == 4) start = 1'b1;
        end
        for (int i = 0; i < KK; i++) push_elem(px[i], toggle);
        s_elem_tvalid = 1'b0;
        wait_idle();
    endtask

    task automatic check_words(input string tag);
        chk32({tag, " word count"}, BW'(obs_q.size()), BW'(NWRD));
        for (int i = 0; i < NWRD; i++) begin
            chk32($sformatf("%s word %0d", tag, i),
                  (obs_q.size() > i) ? obs_q[i] : 32'hdeadbeef, gold[i]);
        end
    endtask

    initial begin
        int base;
        fork
            compare_loop();
            ready_driver();
            g0_monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk1("reset busy", busy, 1'b0);
        chk1("reset done", done, 1'b0);
        chk1("reset s_elem_tready", s_elem_tready, 1'b0);
        chk1("reset m_axis_tvalid", m_axis_tvalid, 1'b0);
        chk32("reset m_axis_tdata", m_axis_tdata, '0);
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Weights 1..9 then pixel rows, ready always high.
        obs_q.delete();
        base = done_cnt;
        run_frame(1'b0, 1'b0);
        check_words("basic");
        chk32("basic done pulses", BW'(done_cnt - base), 32'd1);

        // Five-cycle back-pressure on every word.
        obs_q.delete();
        stall_mode   = 1'b1;
        stall_cycles = 0;
        run_frame(1'b0, 1'b0);
        stall_mode = 1'b0;
        check_words("stall");
        chk32("stall cycles", BW'(stall_cycles), BW'(5 * NWRD));

        // Element valid toggled every other cycle.
        obs_q.delete();
        run_frame(1'b1, 1'b0);
        check_words("toggle");

        // Reset mid-row after two pixels, then a clean frame.
        start         = 1'b1;
        s_elem_tdata  = 8'd1;
        s_elem_tvalid = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < KK; i++) push_elem(DW'(i + 1), 1'b0);
        push_elem(px[0], 1'b0);
        push_elem(px[1], 1'b0);
        s_elem_tvalid = 1'b0;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        chk1("midreset busy", busy, 1'b0);
        chk1("midreset done", done, 1'b0);
        chk1("midreset s_elem_tready", s_elem_tready, 1'b0);
        chk1("midreset m_axis_tvalid", m_axis_tvalid, 1'b0);
        chk32("midreset m_axis_tdata", m_axis_tdata, '0);
`ifdef FEEDER_TLAST_EN
        chk1("midreset m_axis_tlast", m_axis_tlast, 1'b0);
`endif
        rstn = 1'b1;
        obs_q.delete();
        base = done_cnt;
        run_frame(1'b0, 1'b0);
        check_words("after reset");
        chk32("after reset done pulses", BW'(done_cnt - base), 32'd1);

        // Start pulsed while busy is ignored.
        obs_q.delete();
        base = done_cnt;
        run_frame(1'b0, 1'b1);
        check_words("start while busy");
        chk32("start while busy done pulses", BW'(done_cnt - base), 32'd1);
        chk1("start while busy stays idle", busy, 1'b0);

        // Zero-gap instance, also with a start pulse mid-frame.
        g_obs_q.delete();
        g_start = 1'b1;
        g_s_tdata  = 8'd1;
        g_s_tvalid = 1'b1;
        @(posedge clk);
        #1;
        g_start = 1'b0;
        for (int i = 0; i < 2 * KK; i++) begin
            push_g0((i < KK) ? DW'(i + 1) : px[i - KK]);
            g_start = (i == 4);
        end
        g_start    = 1'b0;
        g_s_tvalid = 1'b0;
        wait_idle();
        chk32("g0 word count", BW'(g_obs_q.size()), BW'(NWRD));
        for (int i = 0; i < NWRD; i++) begin
            chk32($sformatf("g0 word %0d", i),
                  (g_obs_q.size() > i) ? g_obs_q[i] : 32'hdeadbeef, gold[i]);
        end
        chk32("g0 done pulses", BW'(g_done_cnt), 32'd1);
        chk1("g0 idle after frame", g_busy, 1'b0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
